// File: rtl/risc16_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : risc16_multicycle_control
// Description : Multi-cycle control FSM for a 16-bit RISC datapath. Sequences
//               fetch / decode / execute / memory / write-back, drives the
//               memory request handshakes with a bounded wait, and parks in a
//               sticky FAULT state on illegal opcodes or handshake timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module risc16_multicycle_control #(
    parameter int OP_LEN      = 3,
    parameter int CNT_W       = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pen,
    input  logic [OP_LEN-1:0] op,
    input  logic              eq,
    input  logic              i_ack,
    input  logic              d_ack,
    output logic              i_req,
    output logic              d_req,
    output logic              ir_wen,
    output logic              pc_wen,
    output logic              reg_wen,
    output logic              d_wen,
    output logic [1:0]        aluFunct,
    output logic              muxSrc1,
    output logic              muxSrc2,
    output logic              muxAddr2,
    output logic [1:0]        muxTrgt,
    output logic [1:0]        muxPc,
    output logic [2:0]        fsm_state,
    output logic              fault
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_ADDI = 3'b001;
    localparam logic [2:0] c_OP_NAND = 3'b010;
    localparam logic [2:0] c_OP_LUI  = 3'b011;
    localparam logic [2:0] c_OP_SW   = 3'b100;
    localparam logic [2:0] c_OP_LW   = 3'b101;
    localparam logic [2:0] c_OP_BEQ  = 3'b110;
    localparam logic [2:0] c_OP_JALR = 3'b111;

    localparam logic [CNT_W-1:0] c_ACK_LIMIT = CNT_W'(ACK_TIMEOUT);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;

    logic [2:0] w_op;
    logic       w_op_bad;
    logic       w_is_sw;
    logic       w_is_lw;
    state_t     w_retire_next;

    assign w_op    = op[2:0];
    assign w_is_sw = (w_op == c_OP_SW);
    assign w_is_lw = (w_op == c_OP_LW);

    // Where the FSM goes when the current instruction retires this cycle:
    // run enable is only honoured at instruction boundaries.
    assign w_retire_next = pen ? S_FETCH : S_IDLE;

    // Opcode bits above the base 3-bit ISA are reserved; any set bit is illegal.
    generate
        if (OP_LEN > 3) begin : g_wide_op
            assign w_op_bad = |op[OP_LEN-1:3];
        end else begin : g_base_op
            assign w_op_bad = 1'b0;
        end
    endgenerate

    // State sequencing and handshake wait counter. The counter is cleared on
    // every cycle that is not an unacknowledged FETCH/MEM wait, so it always
    // starts from zero on entry to either waiting state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            cnt_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (pen) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // An ack in the same cycle as the timeout wins.
                    if (i_ack) begin
                        state_q <= S_DECODE;
                    end else if (cnt_q == c_ACK_LIMIT) begin
                        state_q <= S_FAULT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    state_q <= w_op_bad ? S_FAULT : S_EXEC;
                end
                S_EXEC: begin
                    case (w_op)
                        c_OP_SW, c_OP_LW:    state_q <= S_MEM;
                        c_OP_BEQ, c_OP_JALR: state_q <= w_retire_next;
                        default:             state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (d_ack) begin
                        state_q <= w_is_sw ? w_retire_next : S_WB;
                    end else if (cnt_q == c_ACK_LIMIT) begin
                        state_q <= S_FAULT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WB: begin
                    state_q <= w_retire_next;
                end
                S_FAULT: begin
                    // Sticky: only reset leaves FAULT.
                    state_q <= S_FAULT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fsm_state = state_q;
    assign fault     = (state_q == S_FAULT);

    // Datapath controls decoded from the current state, opcode and acks; all
    // controls idle at zero so reset and FAULT drop every request and enable.
    always_comb begin
        i_req    = 1'b0;
        d_req    = 1'b0;
        ir_wen   = 1'b0;
        pc_wen   = 1'b0;
        reg_wen  = 1'b0;
        d_wen    = 1'b0;
        aluFunct = 2'b00;
        muxSrc1  = 1'b0;
        muxSrc2  = 1'b0;
        muxAddr2 = 1'b0;
        muxTrgt  = 2'b00;
        muxPc    = 2'b00;
        case (state_q)
            S_FETCH: begin
                i_req  = 1'b1;
                ir_wen = i_ack;
            end
            S_EXEC: begin
                case (w_op)
                    c_OP_ADD: begin
                        aluFunct = 2'b00;
                    end
                    c_OP_NAND: begin
                        aluFunct = 2'b01;
                    end
                    c_OP_ADDI: begin
                        muxSrc2 = 1'b1;
                    end
                    c_OP_LUI: begin
                        aluFunct = 2'b10;
                        muxSrc1  = 1'b1;
                    end
                    c_OP_SW, c_OP_LW: begin
                        muxSrc2  = 1'b1;
                        muxAddr2 = 1'b1;
                    end
                    c_OP_BEQ: begin
                        aluFunct = 2'b11;
                        muxAddr2 = 1'b1;
                        pc_wen   = 1'b1;
                        muxPc    = eq ? 2'b01 : 2'b00;
                    end
                    c_OP_JALR: begin
                        reg_wen = 1'b1;
                        muxTrgt = 2'b10;
                        pc_wen  = 1'b1;
                        muxPc   = 2'b10;
                    end
                endcase
            end
            S_MEM: begin
                d_req    = 1'b1;
                muxAddr2 = 1'b1;
                muxSrc2  = 1'b1;
                d_wen    = w_is_sw;
                // A store retires on its ack, advancing PC to PC+1.
                pc_wen   = d_ack & w_is_sw;
            end
            S_WB: begin
                reg_wen = 1'b1;
                muxTrgt = w_is_lw ? 2'b01 : 2'b00;
                pc_wen  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
